// File: rtl/button_pkg.sv
// Shared definitions for the button conditioner: FSM encoding, button count,
// counter widths and the lowest-index priority picker.
package button_pkg;

  localparam int NUM_BUTTONS = 6;
  localparam int DEB_CNT_W   = 16;
  localparam int RPT_CNT_W   = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIRE = 2'd1,
    ST_HELD = 2'd2
  } btn_state_t;

  // One-hot of the lowest set bit; all-zero in, all-zero out.
  function automatic logic [NUM_BUTTONS-1:0] lowest_onehot(input logic [NUM_BUTTONS-1:0] v);
    logic [NUM_BUTTONS-1:0] r;
    r = '0;
    for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// One button bit: 2-flop synchronizer, stability counter and debounced level.
module debounce_cell
  import button_pkg::*;
#(
  parameter logic [DEB_CNT_W-1:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_stable
);

  localparam logic [DEB_CNT_W-1:0] CNT_TC = DEBOUNCE_CYCLES - DEB_CNT_W'(1);

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_stable;
  logic [DEB_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_TC) begin
        // DEBOUNCE_CYCLES consecutive differing samples accepted as a new level
        r_stable <= ~r_stable;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + DEB_CNT_W'(1);
      end
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/button_conditioner.sv
// Six-button debouncer with single-cycle one-hot press pulses.
// Define BUTTON_REPEAT_EN to add auto-repeat pulses while the captured button stays held.
module button_conditioner
  import button_pkg::*;
#(
  parameter logic [DEB_CNT_W-1:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [RPT_CNT_W-1:0] REPEAT_DELAY    = 24'd5000000,
  parameter logic [RPT_CNT_W-1:0] REPEAT_PERIOD   = 24'd2500000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] raw_btn,
  output logic [NUM_BUTTONS-1:0] userin,
  output logic [NUM_BUTTONS-1:0] stable,
  output logic                   busy
);

  logic [NUM_BUTTONS-1:0] w_stable;
  logic [NUM_BUTTONS-1:0] w_press;
  logic [NUM_BUTTONS-1:0] w_userin_next;
  logic [NUM_BUTTONS-1:0] r_stable_d;
  logic [NUM_BUTTONS-1:0] r_userin;
  btn_state_t             r_state;
  btn_state_t             w_state_next;

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_deb
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk     (clk),
      .reset   (reset),
      .i_raw   (raw_btn[g]),
      .o_stable(w_stable[g])
    );
  end

  // Only rising debounced levels count as presses; releases are silent.
  assign w_press = w_stable & ~r_stable_d;

`ifdef BUTTON_REPEAT_EN
  logic [NUM_BUTTONS-1:0] r_capture;
  logic [RPT_CNT_W-1:0]   r_rpt_cnt;
`else
  logic w_unused_rpt;
  assign w_unused_rpt = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

  always_comb begin
    w_state_next  = r_state;
    w_userin_next = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (|w_press) begin
          w_state_next  = ST_FIRE;
          w_userin_next = lowest_onehot(w_press);
        end
      end
      ST_FIRE: w_state_next = ST_HELD;
      ST_HELD: begin
        if (w_stable == '0) begin
          w_state_next = ST_IDLE;
        end
`ifdef BUTTON_REPEAT_EN
        if ((|(w_stable & r_capture)) && (r_rpt_cnt == '0)) begin
          w_userin_next = r_capture;
        end
`endif
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_userin   <= '0;
      r_stable_d <= '0;
    end else begin
      r_state    <= w_state_next;
      r_userin   <= w_userin_next;
      r_stable_d <= w_stable;
    end
  end

`ifdef BUTTON_REPEAT_EN
  // Down-counter loaded on entry to FIRE so terminal count lands REPEAT_DELAY
  // cycles after the first pulse, then reloaded for each REPEAT_PERIOD.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_capture <= '0;
      r_rpt_cnt <= '0;
    end else begin
      if (r_state == ST_IDLE && w_state_next == ST_FIRE) begin
        r_capture <= w_userin_next;
        r_rpt_cnt <= REPEAT_DELAY - RPT_CNT_W'(1);
      end else if (r_state == ST_HELD && r_rpt_cnt == '0) begin
        r_rpt_cnt <= REPEAT_PERIOD - RPT_CNT_W'(1);
      end else if (r_rpt_cnt != '0) begin
        r_rpt_cnt <= r_rpt_cnt - RPT_CNT_W'(1);
      end
    end
  end
`endif

  assign userin = r_userin;
  assign stable = w_stable;
  assign busy   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] raw_btn;
  logic [5:0] userin;
  logic [5:0] stable;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES(16'd4),
    .REPEAT_DELAY   (24'd10),
    .REPEAT_PERIOD  (24'd5)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .raw_btn(raw_btn),
    .userin (userin),
    .stable (stable),
    .busy   (busy)
  );

  // One record = raw value driven for len cycles, with outputs expected during them.
  typedef struct {
    string      name;
    logic [5:0] raw;
    int         len;
    logic [5:0] exp_userin;
    logic       exp_busy;
    logic [5:0] exp_stable;
  } seg_t;

  seg_t segs[$];

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input string name, input logic [5:0] raw, input int len,
                     input logic [5:0] u, input logic b, input logic [5:0] s);
    seg_t r;
    r.name = name; r.raw = raw; r.len = len;
    r.exp_userin = u; r.exp_busy = b; r.exp_stable = s;
    segs.push_back(r);
  endtask

  // Called at a falling edge; outputs sampled there reflect the current cycle.
  task automatic run_segs();
    foreach (segs[j]) begin
      for (int i = 0; i < segs[j].len; i++) begin
        chk({segs[j].name, "_userin"}, userin, segs[j].exp_userin);
        chk({segs[j].name, "_busy"}, {5'b0, busy}, {5'b0, segs[j].exp_busy});
        chk({segs[j].name, "_stable"}, stable, segs[j].exp_stable);
        raw_btn = segs[j].raw;
        @(negedge clk);
      end
    end
    segs.delete();
  endtask

  function automatic logic [5:0] rpt_expect(input int k);
`ifdef BUTTON_REPEAT_EN
    if (k == 0 || k == 10 || k == 15 || k == 20 || k == 25 || k == 30) return 6'b010000;
`else
    if (k == 0) return 6'b010000;
`endif
    return 6'b000000;
  endfunction

  initial begin
    reset   = 1'b0;
    raw_btn = 6'b0;
    repeat (2) @(negedge clk);
    chk("rst_userin", userin, 6'b0);
    chk("rst_stable", stable, 6'b0);
    chk("rst_busy", {5'b0, busy}, 6'b0);
    reset = 1'b1;

    // Single press of bit 2: pulse in cycle 7 only, busy until release settles.
    add("single_pre",   6'b000100, 6, 6'b000000, 1'b0, 6'b000000);
    add("single_stab",  6'b000100, 1, 6'b000000, 1'b0, 6'b000100);
    add("single_pulse", 6'b000100, 1, 6'b000100, 1'b1, 6'b000100);
    add("single_held",  6'b000100, 4, 6'b000000, 1'b1, 6'b000100);
    add("single_rel",   6'b000000, 6, 6'b000000, 1'b1, 6'b000100);
    add("single_rel2",  6'b000000, 1, 6'b000000, 1'b1, 6'b000000);
    add("single_idle",  6'b000000, 4, 6'b000000, 1'b0, 6'b000000);
    run_segs();

    // Bit 0 bouncing every 2 cycles never reaches the debounce threshold.
    for (int i = 0; i < 10; i++) begin
      add("bounce_hi", 6'b000001, 2, 6'b000000, 1'b0, 6'b000000);
      add("bounce_lo", 6'b000000, 2, 6'b000000, 1'b0, 6'b000000);
    end
    add("bounce_tail", 6'b000000, 6, 6'b000000, 1'b0, 6'b000000);
    run_segs();

    // Bits 1 and 5 together: lowest wins, releasing bit 1 gives no pulse for bit 5.
    add("pair_pre",    6'b100010, 6, 6'b000000, 1'b0, 6'b000000);
    add("pair_stab",   6'b100010, 1, 6'b000000, 1'b0, 6'b100010);
    add("pair_pulse",  6'b100010, 1, 6'b000010, 1'b1, 6'b100010);
    add("pair_held",   6'b100010, 4, 6'b000000, 1'b1, 6'b100010);
    add("pair_rel1",   6'b100000, 6, 6'b000000, 1'b1, 6'b100010);
    add("pair_only5",  6'b100000, 1, 6'b000000, 1'b1, 6'b100000);
    add("pair_hold5",  6'b100000, 6, 6'b000000, 1'b1, 6'b100000);
    add("pair_rel5",   6'b000000, 6, 6'b000000, 1'b1, 6'b100000);
    add("pair_rel5b",  6'b000000, 1, 6'b000000, 1'b1, 6'b000000);
    add("pair_idle",   6'b000000, 3, 6'b000000, 1'b0, 6'b000000);
    run_segs();

    // Reset after stable[3] rises but before the pulse: event discarded, re-debounced.
    for (int c = 0; c < 6; c++) begin
      chk("rstmid_pre_stable", stable, 6'b0);
      chk("rstmid_pre_userin", userin, 6'b0);
      raw_btn = 6'b001000;
      @(negedge clk);
    end
    chk("rstmid_stab", stable, 6'b001000);
    chk("rstmid_nopulse", userin, 6'b0);
    reset = 1'b0;
    #1;
    chk("rstmid_async_stable", stable, 6'b0);
    chk("rstmid_async_busy", {5'b0, busy}, 6'b0);
    @(negedge clk);
    chk("rstmid_in_rst_userin", userin, 6'b0);
    chk("rstmid_in_rst_stable", stable, 6'b0);
    reset = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk("rstmid_userin", userin, (k == 7) ? 6'b001000 : 6'b000000);
      chk("rstmid_stable", stable, (k >= 6) ? 6'b001000 : 6'b000000);
      chk("rstmid_busy", {5'b0, busy}, {5'b0, (k >= 7)});
    end
    raw_btn = 6'b0;
    repeat (8) @(negedge clk);
    chk("rstmid_end_stable", stable, 6'b0);
    chk("rstmid_end_busy", {5'b0, busy}, 6'b0);

    // Bit 4 held ~30 cycles past the first pulse (cycle 7); raw released at cycle 33.
    for (int c = 0; c <= 52; c++) begin
      chk("repeat_userin", userin, (c >= 7) ? rpt_expect(c - 7) : 6'b000000);
      raw_btn = (c < 33) ? 6'b010000 : 6'b000000;
      @(negedge clk);
    end
    chk("repeat_end_busy", {5'b0, busy}, 6'b0);
    chk("repeat_end_stable", stable, 6'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
